mb8_arbiter: RTL

Sequencer and arbiter for the single 8-bit memory port (spram) shared by the outer interpreter's bus masters: finder, atoier, eForth inner interpreter, and comma. It replaces ad-hoc per-state bus muxing with registered one-hot grants, a hold/release handshake and a bounded hold time. The read-data valid strobe is returned to the requester that issued the read.

---
 rtl/mb8_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mb8_arbiter.sv
// mb8_arbiter: sequencer and arbiter for the single 8-bit spram port shared by
// the outer interpreter's bus masters (0 finder, 1 atoier, 2 exe, 3 comma).
// One-hot registered grants, a hold/release handshake and a bounded hold time.
// Optional feature macro: EFORTH1_ARB_RR_EN
//   defined   -> round-robin arbitration (search starts after the last winner)
//   undefined -> fixed priority, lowest index wins
module mb8_arbiter #(
    parameter int NREQ     = 4,
    parameter int ASZ      = 17,
    parameter int MSZ      = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*ASZ-1:0] ai,
    input  logic [NREQ*MSZ-1:0] vi,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvld,
    output logic [MSZ-1:0]      rd,
    output logic                mem_we,
    output logic [ASZ-1:0]      mem_ai,
    output logic [MSZ-1:0]      mem_vi,
    input  logic [MSZ-1:0]      mem,
    output logic                bsy
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [NREQ-1:0] ONE_OH  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] rvld_r;
    logic            bsy_r;
    logic [HW-1:0]   hold_r;

    logic [NREQ-1:0] cand_s;
    logic            win_found_s;
    logic [IW-1:0]   win_idx_s;
    logic [NREQ-1:0] win_oh_s;
    logic            owner_req_s;
    logic            preempt_s;
    logic            mem_we_s;
    logic [ASZ-1:0]  mem_ai_s;
    logic [MSZ-1:0]  mem_vi_s;

`ifdef EFORTH1_ARB_RR_EN
    logic [IW-1:0]   ptr_r;

    // Round-robin pick: first candidate found after ptr, wrapping modulo NREQ.
    function automatic logic [IW:0] pick_rr(input logic [NREQ-1:0] c,
                                            input logic [IW-1:0]   p);
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(p) + k) % NREQ;
            if (c[j] && !found) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction
`else
    // Fixed-priority pick: lowest candidate index wins.
    function automatic logic [IW:0] pick_fixed(input logic [NREQ-1:0] c);
        logic          found;
        logic [IW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (c[i] && !found) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        return {found, idx};
    endfunction
`endif

    // Arbitration: the current owner is never a candidate, so a releasing or
    // preempted owner cannot re-win at the same edge. In IDLE gnt_r is zero.
    always_comb begin
        cand_s = req & ~gnt_r;
`ifdef EFORTH1_ARB_RR_EN
        {win_found_s, win_idx_s} = pick_rr(cand_s, ptr_r);
`else
        {win_found_s, win_idx_s} = pick_fixed(cand_s);
`endif
        win_oh_s    = win_found_s ? (ONE_OH << win_idx_s) : {NREQ{1'b0}};
        owner_req_s = |(req & gnt_r);
        // >= rather than == so a counter that saturated while nobody waited
        // still yields to a late arrival instead of starving it.
        preempt_s   = (MAX_HOLD != 0) && (hold_r >= HOLD_LAST) && win_found_s;
    end

    // Bus mux: OR of masked requester buses; grant is one-hot or zero, so no
    // grant means an all-zero bus and never a write.
    always_comb begin
        mem_we_s = 1'b0;
        mem_ai_s = {ASZ{1'b0}};
        mem_vi_s = {MSZ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            mem_we_s = mem_we_s | (we[i] & gnt_r[i]);
            mem_ai_s = mem_ai_s | (ai[i*ASZ +: ASZ] & {ASZ{gnt_r[i]}});
            mem_vi_s = mem_vi_s | (vi[i*MSZ +: MSZ] & {MSZ{gnt_r[i]}});
        end
    end

    // Grant FSM: owner tracking, hold counter, pointer and read-valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NREQ{1'b0}};
            rvld_r  <= {NREQ{1'b0}};
            bsy_r   <= 1'b0;
            hold_r  <= {HW{1'b0}};
`ifdef EFORTH1_ARB_RR_EN
            ptr_r   <= IW'(NREQ - 1);
`endif
        end else begin
            rvld_r <= gnt_r & ~we;
            case (state_r)
                ST_IDLE: begin
                    hold_r <= {HW{1'b0}};
                    if (win_found_s) begin
                        state_r <= ST_OWN;
                        gnt_r   <= win_oh_s;
                        bsy_r   <= 1'b1;
`ifdef EFORTH1_ARB_RR_EN
                        ptr_r   <= win_idx_s;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {NREQ{1'b0}};
                        bsy_r   <= 1'b0;
                    end
                end
                ST_OWN: begin
                    // Release takes precedence; release+preempt behaves alike.
                    if (!owner_req_s || preempt_s) begin
                        hold_r <= {HW{1'b0}};
                        if (win_found_s) begin
                            state_r <= ST_OWN;
                            gnt_r   <= win_oh_s;
                            bsy_r   <= 1'b1;
`ifdef EFORTH1_ARB_RR_EN
                            ptr_r   <= win_idx_s;
`endif
                        end else begin
                            state_r <= ST_IDLE;
                            gnt_r   <= {NREQ{1'b0}};
                            bsy_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_OWN;
                        gnt_r   <= gnt_r;
                        bsy_r   <= 1'b1;
                        if (hold_r < HOLD_MAX) begin
                            hold_r <= hold_r + HW'(1);
                        end else begin
                            hold_r <= hold_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {NREQ{1'b0}};
                    bsy_r   <= 1'b0;
                    hold_r  <= {HW{1'b0}};
                end
            endcase
        end
    end

    assign gnt    = gnt_r;
    assign rvld   = rvld_r;
    assign bsy    = bsy_r;
    assign rd     = mem;
    assign mem_we = mem_we_s;
    assign mem_ai = mem_ai_s;
    assign mem_vi = mem_vi_s;

endmodule
